// File: rtl/anthem_char_scheduler.sv
// Round-robin word player: arbitrates two requesters, looks up a word in an external table and
// streams its characters from a synchronous ROM. Define SCHED_ABORT_EN to add abort/aborted.
module anthem_char_scheduler #(
    parameter int ADDR_W      = 8,
    parameter int WORD_W      = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [WORD_W-1:0] req0_word,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WORD_W-1:0] req1_word,
    output logic              req1_ready,
    output logic [WORD_W-1:0] tbl_idx,
    input  logic [ADDR_W-1:0] tbl_start,
    input  logic [ADDR_W-1:0] tbl_len,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        char_out,
    output logic              char_valid,
    output logic              busy,
    output logic              grant_id,
`ifdef SCHED_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_FETCH, S_WAIT, S_HOLD, S_GAP, S_DONE
    } state_t;

    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [ADDR_W-1:0] offset_inc;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        char_q, char_d;
`ifdef SCHED_ABORT_EN
    logic              aborted_q, aborted_d;
`endif

    // Only the IDLE state grants; on contention the requester not served last time wins.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == S_IDLE) begin
            req0_ready = req0_valid & (~req1_valid | last_q);
            req1_ready = req1_valid & (~req0_valid | ~last_q);
        end
    end

    assign offset_inc = offset_q + ADDR_W'(1);

    always_comb begin
        // NOTE: every next-state signal gets its default first, so no path can infer a latch.
        state_d  = state_q;
        word_d   = word_q;
        grant_d  = grant_q;
        last_d   = last_q;
        start_d  = start_q;
        len_d    = len_q;
        offset_d = offset_q;
        cnt_d    = cnt_q;
        char_d   = char_q;
`ifdef SCHED_ABORT_EN
        aborted_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req0_ready | req1_ready) begin
                    state_d = S_LOOKUP;
                    grant_d = req1_ready;
                    last_d  = req1_ready;
                    word_d  = req1_ready ? req1_word : req0_word;
                end
            end
            S_LOOKUP: begin
                start_d  = tbl_start;
                len_d    = tbl_len;
                offset_d = '0;
                state_d  = (tbl_len == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                char_d  = rom_data;
                cnt_d   = HOLD_LAST;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (GAP_CYCLES == 0) begin
                    offset_d = offset_inc;
                    state_d  = (offset_inc == len_q) ? S_DONE : S_FETCH;
                end else begin
                    cnt_d   = GAP_LAST;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    offset_d = offset_inc;
                    state_d  = (offset_inc == len_q) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef SCHED_ABORT_EN
        // DONE is already terminating, so an abort there must not stretch the done pulse.
        if (abort && state_q != S_IDLE && state_q != S_DONE) begin
            state_d   = S_DONE;
            aborted_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            start_q   <= '0;
            len_q     <= '0;
            offset_q  <= '0;
            cnt_q     <= '0;
            char_q    <= '0;
`ifdef SCHED_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            start_q   <= start_d;
            len_q     <= len_d;
            offset_q  <= offset_d;
            cnt_q     <= cnt_d;
            char_q    <= char_d;
`ifdef SCHED_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign tbl_idx    = word_q;
    assign rom_rd     = (state_q == S_FETCH);
    assign rom_addr   = start_q + offset_q;
    assign char_valid = (state_q == S_HOLD);
    assign char_out   = char_valid ? char_q : 8'h00;
    assign busy       = (state_q != S_IDLE);
    assign grant_id   = grant_q;
    assign done       = (state_q == S_DONE);
`ifdef SCHED_ABORT_EN
    assign aborted    = aborted_q;
`endif

endmodule

// File: tb/tb_anthem_char_scheduler.sv
// Scoreboard bench for anthem_char_scheduler: a cycle-stamped schedule model predicts ROM reads,
// character starts, done pulses and per-cycle ready/busy; a negedge monitor consumes them.
module tb_anthem_char_scheduler;

    localparam int HOLD = 4;
    localparam int GAP  = 2;
    localparam int PER  = HOLD + GAP + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, req0_valid, req1_valid;
    logic [3:0] req0_word, req1_word, tbl_idx;
    logic [7:0] tbl_start, tbl_len, rom_addr, rom_data, char_out;
    logic       req0_ready, req1_ready, rom_rd, char_valid, busy, grant_id, done;
`ifdef SCHED_ABORT_EN
    logic       abort, aborted;
`endif

    logic [7:0] rom_mem [256];
    logic [7:0] tbl_s [16];
    logic [7:0] tbl_l [16];

    assign tbl_start = tbl_s[tbl_idx];
    assign tbl_len   = tbl_l[tbl_idx];

    // Synchronous ROM; data outside the read response is garbage.
    always @(posedge clk) rom_data <= rom_rd ? rom_mem[rom_addr] : 8'($urandom);

    anthem_char_scheduler #(
        .ADDR_W(8), .WORD_W(4), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_word(req0_word), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_word(req1_word), .req1_ready(req1_ready),
        .tbl_idx(tbl_idx), .tbl_start(tbl_start), .tbl_len(tbl_len),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .char_out(char_out), .char_valid(char_valid), .busy(busy), .grant_id(grant_id),
`ifdef SCHED_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .done(done)
    );

    typedef struct { int cyc; logic [7:0] val; } ev_t;
    typedef struct { int cyc; logic gid; logic ab; } done_t;
    typedef struct { int cyc; logic r0; logic r1; logic busy; } cyc_t;

    ev_t   addr_q [$];
    ev_t   chr_q  [$];
    done_t done_q [$];
    cyc_t  cyc_q  [$];

    int   cyc = 0;
    int   busy_to = -1;
    int   last_acc = 0;
    int   n_acc = 0;
    logic last_grant = 1'b1;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
    endtask

    // Whole word timeline from the accept cycle t: fetch k at t+2+PER*k, shown from t+4+PER*k.
    task automatic schedule(input int t, input logic win, input logic [3:0] word);
        int ln;
        logic [7:0] a;
        ln = int'(tbl_l[word]);
        for (int k = 0; k < ln; k++) begin
            a = tbl_s[word] + 8'(k);
            addr_q.push_back('{cyc: t + 2 + PER * k, val: a});
            chr_q.push_back('{cyc: t + 4 + PER * k, val: rom_mem[a]});
        end
        done_q.push_back('{cyc: t + 2 + PER * ln, gid: win, ab: 1'b0});
        busy_to    = t + 2 + PER * ln;
        last_grant = win;
        last_acc   = t;
        n_acc++;
    endtask

    task automatic flush(input int c);
        while (addr_q.size() > 0 && addr_q[$].cyc > c) void'(addr_q.pop_back());
        while (chr_q.size() > 0 && chr_q[$].cyc > c) void'(chr_q.pop_back());
        while (done_q.size() > 0 && done_q[$].cyc > c) void'(done_q.pop_back());
    endtask

    // Drive one cycle's inputs, advance the model, then move to just after the next edge.
    task automatic step(input logic v0, input logic [3:0] w0, input logic v1, input logic [3:0] w1,
                        input logic do_rst, input logic do_abort);
        cyc_t e;
        logic win;
        logic eb;
        rst = do_rst;
        req0_valid = v0; req0_word = w0;
        req1_valid = v1; req1_word = w1;
`ifdef SCHED_ABORT_EN
        abort = do_abort;
`endif
        eb = (cyc <= busy_to);
        e = '{cyc: cyc, r0: 1'b0, r1: 1'b0, busy: eb};
        if (do_rst) begin
            flush(cyc);
            busy_to = cyc;
            last_grant = 1'b1;
        end else if (do_abort && eb) begin
            flush(cyc);
            done_q.push_back('{cyc: cyc + 1, gid: last_grant, ab: 1'b1});
            busy_to = cyc + 1;
        end else if (!eb && (v0 || v1)) begin
            win  = (v0 && v1) ? ~last_grant : v1;
            e.r0 = ~win;
            e.r1 = win;
            schedule(cyc, win, win ? w1 : w0);
        end
        cyc_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_until_free();
        while (cyc <= busy_to) step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    logic       rst_prev = 1'b0;
    bit         in_run = 1'b0;
    int         run_len = 0;
    logic [7:0] cur_char = 8'h00;

    always @(negedge clk) begin : monitor
        cyc_t  e;
        ev_t   a;
        done_t d;
        if (mon_en) begin
            if (cyc_q.size() == 0) bad("cycle_expectation");
            else begin
                e = cyc_q.pop_front();
                check("req0_ready", 32'(req0_ready), 32'(e.r0));
                check("req1_ready", 32'(req1_ready), 32'(e.r1));
                check("busy", 32'(busy), 32'(e.busy));
            end
            if (rom_rd) begin
                if (addr_q.size() == 0) bad("rom_rd");
                else begin
                    a = addr_q.pop_front();
                    check("rom_rd_cycle", 32'(cyc), 32'(a.cyc));
                    check("rom_addr", 32'(rom_addr), 32'(a.val));
                end
            end
            if (char_valid) begin
                if (!in_run) begin
                    in_run = 1'b1;
                    run_len = 0;
                    if (chr_q.size() == 0) bad("char_valid");
                    else begin
                        a = chr_q.pop_front();
                        check("char_start_cycle", 32'(cyc), 32'(a.cyc));
                        check("char_value", 32'(char_out), 32'(a.val));
                        cur_char = a.val;
                    end
                end else begin
                    check("char_stable", 32'(char_out), 32'(cur_char));
                end
                run_len++;
            end else begin
                check("char_out_blank", 32'(char_out), 32'h0);
                if (in_run) begin
                    if (!rst_prev) check("hold_len", 32'(run_len), 32'(HOLD));
                    in_run = 1'b0;
                end
            end
            if (done) begin
                if (done_q.size() == 0) bad("done");
                else begin
                    d = done_q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(d.cyc));
                    check("grant_id", 32'(grant_id), 32'(d.gid));
`ifdef SCHED_ABORT_EN
                    check("aborted", 32'(aborted), 32'(d.ab));
`endif
                end
            end
        end
        rst_prev = rst;
    end

    initial begin
        string name;
        int t;
        int target;
        name = "Tajumulco ";
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
        for (int i = 0; i < 10; i++) rom_mem[i] = name[i];
        for (int w = 0; w < 16; w++) begin
            tbl_s[w] = 8'($urandom);
            tbl_l[w] = 8'($urandom_range(0, 6));
        end
        tbl_s[0] = 8'h00; tbl_l[0] = 8'd10;
        tbl_s[1] = 8'hFE; tbl_l[1] = 8'd4;
        tbl_l[2] = 8'd0;
        tbl_s[3] = 8'h40; tbl_l[3] = 8'd255;
        tbl_s[4] = 8'h20; tbl_l[4] = 8'd2;
        tbl_s[5] = 8'h80; tbl_l[5] = 8'd3;

        rst = 1'b1;
        req0_valid = 1'b0; req0_word = '0;
        req1_valid = 1'b0; req1_word = '0;
`ifdef SCHED_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_char_out", 32'(char_out), 32'h0);
        check("rst_char_valid", 32'(char_valid), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_rom_rd", 32'(rom_rd), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rom_addr", 32'(rom_addr), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);

        mon_en = 1'b1;
        // Single word "Tajumulco ", then zero length, then address wrap.
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        idle_until_free();
        step(1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 1'b0);
        idle_until_free();
        step(1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0);
        idle_until_free();

        // Contention straight out of reset: grants must alternate starting with req0.
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        target = n_acc + 4;
        while (n_acc < target) step(1'b1, 4'd4, 1'b1, 4'd5, 1'b0, 1'b0);
        idle_until_free();

        // Reset in the middle of the third character's hold window.
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        t = last_acc;
        while (cyc < t + 4 + 2 * PER + 1) step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("midrst_char_valid", 32'(char_valid), 32'h0);
        check("midrst_char_out", 32'(char_out), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_grant_id", 32'(grant_id), 32'h0);
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        idle_until_free();

        // Longest legal word.
        step(1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0);
        idle_until_free();

        for (int i = 0; i < 300; i++) begin
            logic [3:0] a, b;
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            if (a == 4'd3) a = 4'd4;
            if (b == 4'd3) b = 4'd5;
            step($urandom_range(0, 3) == 0, a, $urandom_range(0, 3) == 0, b, 1'b0, 1'b0);
        end
        idle_until_free();

`ifdef SCHED_ABORT_EN
        // Abort during the gap after the second character.
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        t = last_acc;
        while (cyc < t + 4 + PER + HOLD) step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        idle_until_free();
`endif

        repeat (6) step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        mon_en = 1'b0;
        check("pending_rom_reads", 32'(addr_q.size()), 32'h0);
        check("pending_chars", 32'(chr_q.size()), 32'h0);
        check("pending_done", 32'(done_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
